ahb_sram_sub: RTL and testbench



---
 rtl/ahb_sram_sub.sv | 134 +++++++++++++
 tb/tb_ahb_sram_sub.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_sub.sv
// AHB-Lite subordinate in front of a word-organised SRAM array.
// Pipelined NONSEQ/SEQ transfers, lane-correct writes, fixed wait states and a two-cycle ERROR response.
`timescale 1ns/1ps
module ahb_sram_sub #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;

  logic [31:0] mem [DEPTH];

  logic [31:0] off;
  logic        trans_valid, accept, legal, can_accept, wr_en;
  logic [3:0]  be;
  logic [31:0] cur_word, wr_word;

  assign off         = HADDR - BASE_ADDR;
  assign trans_valid = (HTRANS == 2'b10) || (HTRANS == 2'b11);
  assign accept      = HSEL && HREADY && trans_valid;
  assign legal       = (HSIZE <= 3'd2)
                    && !((HSIZE == 3'd1) && HADDR[0])
                    && !((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                    && ({1'b0, off} < SPAN);

  // A new address phase is only taken when this subordinate is not stalling the bus.
  assign can_accept = (state_q == S_IDLE) || (state_q == S_ERR2)
                   || ((state_q == S_DATA) && (cnt_q == 4'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
    if (can_accept) begin
      if (accept) begin
        idx_d   = off[AW+1:2];
        lane_d  = HADDR[1:0];
        size_d  = HSIZE[1:0];
        write_d = HWRITE;
        if (legal) begin
          state_d = S_DATA;
          cnt_d   = 4'(WAIT_STATES);
        end else begin
          state_d = S_ERR1;
          cnt_d   = 4'd0;
        end
      end else begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    end else if (state_q == S_DATA) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be = 4'b0001 << lane_q;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign cur_word = mem[idx_q];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wr_word[8*gi +: 8] = be[gi] ? HWDATA[8*gi +: 8] : cur_word[8*gi +: 8];
  end

  // State is reset asynchronously, so an aborted write never reaches the array.
  assign wr_en = (state_q == S_DATA) && (cnt_q == 4'd0) && write_q;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[idx_q] <= wr_word;
    end
  end

  assign HREADYOUT = !((state_q == S_ERR1) || ((state_q == S_DATA) && (cnt_q != 4'd0)));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = ((state_q == S_DATA) && !write_q) ? cur_word : 32'h0;

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Directed bench for ahb_sram_sub: one instance with one wait state, one with zero wait states.
`timescale 1ns/1ps
module tb_ahb_sram_sub;

  logic clk;
  int   checks;
  int   failures;

  // Instance A: WAIT_STATES = 1
  logic        a_nrst, a_hsel, a_hwrite, a_hreadyout, a_hresp;
  logic [31:0] a_haddr, a_hwdata, a_hrdata;
  logic [2:0]  a_hsize;
  logic [1:0]  a_htrans;

  // Instance B: WAIT_STATES = 0
  logic        b_nrst, b_hsel, b_hwrite, b_hreadyout, b_hresp;
  logic [31:0] b_haddr, b_hwdata, b_hrdata;
  logic [2:0]  b_hsize;
  logic [1:0]  b_htrans;

  ahb_sram_sub #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_a (
    .CLK(clk), .nRST(a_nrst), .HSEL(a_hsel), .HADDR(a_haddr), .HWRITE(a_hwrite),
    .HSIZE(a_hsize), .HTRANS(a_htrans), .HWDATA(a_hwdata), .HREADY(a_hreadyout),
    .HRDATA(a_hrdata), .HREADYOUT(a_hreadyout), .HRESP(a_hresp)
  );

  ahb_sram_sub #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_b (
    .CLK(clk), .nRST(b_nrst), .HSEL(b_hsel), .HADDR(b_haddr), .HWRITE(b_hwrite),
    .HSIZE(b_hsize), .HTRANS(b_htrans), .HWDATA(b_hwdata), .HREADY(b_hreadyout),
    .HRDATA(b_hrdata), .HREADYOUT(b_hreadyout), .HRESP(b_hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Single non-pipelined transfer on instance A; returns after the data phase completes.
  task automatic xfer_a(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic resp_first, output logic resp_last, output int waits);
    a_hsel   = 1'b1;
    a_htrans = 2'b10;
    a_haddr  = addr;
    a_hwrite = wr;
    a_hsize  = size;
    @(posedge clk); #1;
    a_htrans = 2'b00;
    a_hwdata = wdata;
    waits      = 0;
    resp_first = a_hresp;
    while (!a_hreadyout && waits < 20) begin
      waits++;
      @(posedge clk); #1;
    end
    resp_last = a_hresp;
    rdata     = a_hrdata;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        rf, rl;
  int          w;

  initial begin
    checks   = 0;
    failures = 0;
    a_nrst = 1'b0; a_hsel = 1'b0; a_haddr = '0; a_hwrite = 1'b0; a_hsize = 3'd2;
    a_htrans = 2'b00; a_hwdata = '0;
    b_nrst = 1'b0; b_hsel = 1'b0; b_haddr = '0; b_hwrite = 1'b0; b_hsize = 3'd2;
    b_htrans = 2'b00; b_hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hreadyout", {31'd0, a_hreadyout}, 32'd1);
    check_val("rst_hresp", {31'd0, a_hresp}, 32'd0);
    check_val("rst_hrdata", a_hrdata, 32'd0);
    a_nrst = 1'b1; b_nrst = 1'b1;

    // IDLE transfer while selected
    a_hsel = 1'b1; a_htrans = 2'b00; a_haddr = 32'h10;
    @(posedge clk); #1;
    check_val("idle_hreadyout", {31'd0, a_hreadyout}, 32'd1);
    check_val("idle_hresp", {31'd0, a_hresp}, 32'd0);

    // Word write then read
    xfer_a(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, rf, rl, w);
    check_val("wr10_waits", w, 32'd1);
    check_val("wr10_resp", {31'd0, rl}, 32'd0);
    xfer_a(1'b0, 32'h10, 3'd2, 32'h0, rd, rf, rl, w);
    check_val("rd10_waits", w, 32'd1);
    check_val("rd10_data", rd, 32'hDEADBEEF);

    // Byte and half writes
    xfer_a(1'b1, 32'h11, 3'd0, 32'h0000AA00, rd, rf, rl, w);
    xfer_a(1'b1, 32'h12, 3'd1, 32'h12340000, rd, rf, rl, w);
    xfer_a(1'b0, 32'h10, 3'd2, 32'h0, rd, rf, rl, w);
    check_val("rd10_lanes", rd, 32'h1234AAEF);

    // Misaligned word read and illegal size write
    xfer_a(1'b0, 32'h12, 3'd2, 32'h0, rd, rf, rl, w);
    check_val("misalign_waits", w, 32'd1);
    check_val("misalign_resp1", {31'd0, rf}, 32'd1);
    check_val("misalign_resp2", {31'd0, rl}, 32'd1);
    xfer_a(1'b1, 32'h10, 3'd3, 32'hFFFFFFFF, rd, rf, rl, w);
    check_val("size3_waits", w, 32'd1);
    check_val("size3_resp1", {31'd0, rf}, 32'd1);
    check_val("size3_resp2", {31'd0, rl}, 32'd1);
    xfer_a(1'b0, 32'h10, 3'd2, 32'h0, rd, rf, rl, w);
    check_val("rd10_after_err", rd, 32'h1234AAEF);

    // Range boundary
    xfer_a(1'b1, 32'h1000, 3'd2, 32'h77777777, rd, rf, rl, w);
    check_val("oob_resp", {31'd0, rl}, 32'd1);
    check_val("oob_waits", w, 32'd1);
    xfer_a(1'b1, 32'hFFC, 3'd2, 32'hCAFEF00D, rd, rf, rl, w);
    check_val("top_wr_resp", {31'd0, rl}, 32'd0);
    xfer_a(1'b0, 32'hFFC, 3'd2, 32'h0, rd, rf, rl, w);
    check_val("top_rd_resp", {31'd0, rl}, 32'd0);
    check_val("top_rd_data", rd, 32'hCAFEF00D);
    xfer_a(1'b0, 32'h0, 3'd2, 32'h0, rd, rf, rl, w);
    check_val("rd0_alias_check", rd == 32'h77777777 ? 32'd1 : 32'd0, 32'd0);

    // Reset during the wait cycle of a write discards it
    xfer_a(1'b1, 32'h24, 3'd2, 32'h11112222, rd, rf, rl, w);
    a_htrans = 2'b10; a_haddr = 32'h24; a_hwrite = 1'b1; a_hsize = 3'd2;
    @(posedge clk); #1;
    a_htrans = 2'b00; a_hwdata = 32'h99999999;
    check_val("abort_wait", {31'd0, a_hreadyout}, 32'd0);
    a_nrst = 1'b0;
    #1;
    check_val("abort_hreadyout", {31'd0, a_hreadyout}, 32'd1);
    check_val("abort_hresp", {31'd0, a_hresp}, 32'd0);
    @(posedge clk); #1;
    a_nrst = 1'b1;
    @(posedge clk); #1;
    xfer_a(1'b0, 32'h24, 3'd2, 32'h0, rd, rf, rl, w);
    check_val("rd24_old", rd, 32'h11112222);

    // Instance B: pipelined write then read with zero wait states
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = 32'h20; b_hwrite = 1'b1; b_hsize = 3'd2;
    @(posedge clk); #1;
    b_hwdata = 32'h00000055;
    b_htrans = 2'b10; b_haddr = 32'h20; b_hwrite = 1'b0;
    check_val("pipe_wr_ready", {31'd0, b_hreadyout}, 32'd1);
    check_val("pipe_wr_hrdata", b_hrdata, 32'd0);
    @(posedge clk); #1;
    b_htrans = 2'b00;
    check_val("pipe_rd_ready", {31'd0, b_hreadyout}, 32'd1);
    check_val("pipe_rd_data", b_hrdata, 32'h00000055);
    check_val("pipe_rd_resp", {31'd0, b_hresp}, 32'd0);
    @(posedge clk); #1;
    check_val("pipe_idle_hrdata", b_hrdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
